// File: rtl/sr_cmd_conditioner_pkg.sv
// Shared state encodings, conflict-mode constants and the event resolution helper
// for the SR command conditioner.
package sr_cmd_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam logic [1:0] MODE_DROP     = 2'd0;
    localparam logic [1:0] MODE_SET_WINS = 2'd1;
    localparam logic [1:0] MODE_CLR_WINS = 2'd2;

    typedef struct packed {
        logic set_cmd;
        logic clr_cmd;
        logic conflict;
    } cmd_t;

    // Turns one cycle's set/clear events into at most one command plus a conflict flag.
    function automatic cmd_t resolve_cmd(input logic set_ev, input logic clr_ev,
                                         input logic [1:0] mode);
        cmd_t c;
        c = 3'b000;
        if (set_ev && clr_ev) begin
            c.conflict = 1'b1;
            case (mode)
                MODE_DROP:     c.conflict = 1'b1;
                MODE_SET_WINS: c.set_cmd  = 1'b1;
                MODE_CLR_WINS: c.clr_cmd  = 1'b1;
                default:       c.conflict = 1'b1;
            endcase
        end else begin
            c.set_cmd = set_ev;
            c.clr_cmd = clr_ev;
        end
        return c;
    endfunction

endpackage

// File: rtl/sr_cmd_conditioner_sync_debounce.sv
// One request channel: 2-flop synchronizer, 8-bit debounce counter and a
// registered single-cycle pulse on each debounced 0->1 transition.
module sr_sync_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       level_r;
    logic       rise_r;
    logic [7:0] cnt_r;
    logic       differ_s;
    logic       flip_s;

    // The level flips on the edge that takes the DB_CYCLES-th consecutive differing sample.
    always_comb begin
        differ_s = (sync2_r != level_r);
        flip_s   = differ_s && (cnt_r == DB_LAST);
    end

    // Synchronizer, debounce counter, level and edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            rise_r  <= flip_s && sync2_r;
            if (flip_s) begin
                level_r <= sync2_r;
                cnt_r   <= 8'd0;
            end else if (differ_s) begin
                cnt_r   <= cnt_r + 8'd1;
            end else begin
                cnt_r   <= 8'd0;
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Front end for the SR flip-flop: debounced set/clear requests become one-cycle,
// mutually exclusive s/r pulses separated by a lockout gap.
module sr_cmd_conditioner #(
    parameter int DB_CYCLES     = 4,
    parameter int LOCK_CYCLES   = 3,
    parameter int CONFLICT_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic q_model,
    output logic busy,
    output logic conflict,
    output logic drop
);

    import sr_cmd_conditioner_pkg::*;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);
    localparam logic [1:0] MODE      = 2'(CONFLICT_MODE);

    logic       set_level_s;
    logic       clr_level_s;
    logic       set_ev_s;
    logic       clr_ev_s;
    cmd_t       cmd_s;
    state_e     state_r;
    state_e     state_nxt_s;
    logic [7:0] lock_cnt_r;
    logic [7:0] lock_cnt_nxt_s;
    logic       s_r, r_r, q_r, busy_r, conflict_r, drop_r;
    logic       s_nxt_s, r_nxt_s, q_nxt_s, busy_nxt_s, conflict_nxt_s, drop_nxt_s;

    sr_sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk   (clk),
        .reset (reset),
        .raw   (set_raw),
        .level (set_level_s),
        .rise  (set_ev_s)
    );

    sr_sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk   (clk),
        .reset (reset),
        .raw   (clr_raw),
        .level (clr_level_s),
        .rise  (clr_ev_s)
    );

    assign cmd_s = resolve_cmd(set_ev_s, clr_ev_s, MODE);

    // State and lockout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
        end
    end

    // Next-state logic; a dropped conflict leaves the FSM idle.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_s.set_cmd || cmd_s.clr_cmd) begin
                    state_nxt_s = ST_PULSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (LOCK_CYCLES > 0) begin
                    state_nxt_s = ST_LOCKOUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_r == LOCK_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s    = ST_LOCKOUT;
                    lock_cnt_nxt_s = lock_cnt_r + 8'd1;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic; events seen outside IDLE are discarded and flagged, never queued.
    always_comb begin
        s_nxt_s        = 1'b0;
        r_nxt_s        = 1'b0;
        conflict_nxt_s = 1'b0;
        drop_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_nxt_s        = cmd_s.set_cmd;
                r_nxt_s        = cmd_s.clr_cmd;
                conflict_nxt_s = cmd_s.conflict;
            end
            ST_PULSE, ST_LOCKOUT: drop_nxt_s = set_ev_s | clr_ev_s;
            default:              drop_nxt_s = 1'b0;
        endcase
        if (s_nxt_s) begin
            q_nxt_s = 1'b1;
        end else if (r_nxt_s) begin
            q_nxt_s = 1'b0;
        end else begin
            q_nxt_s = q_r;
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            q_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            s_r        <= s_nxt_s;
            r_r        <= r_nxt_s;
            q_r        <= q_nxt_s;
            busy_r     <= busy_nxt_s;
            conflict_r <= conflict_nxt_s;
            drop_r     <= drop_nxt_s;
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign q_model  = q_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;
    assign drop     = drop_r;

    // Debounced levels are not needed downstream; fold them into nothing.
    logic unused_s;
    assign unused_s = set_level_s ^ clr_level_s;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: three instances (conflict modes 0/1/2) driven in
// parallel and compared every cycle against an edge-indexed behavioural model.
module tb_sr_cmd_conditioner;

    localparam int DB   = 4;
    localparam int LOCK = 3;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic set_raw = 1'b0;
    logic clr_raw = 1'b0;
    logic s_w[3], r_w[3], q_w[3], busy_w[3], conf_w[3], drop_w[3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            sr_cmd_conditioner #(.DB_CYCLES(DB), .LOCK_CYCLES(LOCK), .CONFLICT_MODE(g)) u_dut (
                .clk(clk), .reset(reset), .set_raw(set_raw), .clr_raw(clr_raw),
                .s(s_w[g]), .r(r_w[g]), .q_model(q_w[g]), .busy(busy_w[g]),
                .conflict(conf_w[g]), .drop(drop_w[g])
            );
        end
    endgenerate

    function automatic logic [5:0] dut_vec(input int m);
        return {s_w[m], r_w[m], q_w[m], busy_w[m], conf_w[m], drop_w[m]};
    endfunction

    // ---------------- behavioural reference model ----------------
    // n is the index of the clock edge since reset release (first edge = 0).
    int         n;
    bit         hist[2][64];
    int         last_flip[2];
    bit         lvl[2];
    bit         ev_prev[2];
    int         free_e[3];
    bit         q_m[3];
    logic [5:0] exp_v[3];

    function automatic bit synced(input int ch, input int k);
        if (k < 2) return 1'b0;
        return hist[ch][(k - 2) % 64];
    endfunction

    task automatic model_clear();
        n = -1;
        for (int ch = 0; ch < 2; ch++) begin
            last_flip[ch] = -1;
            lvl[ch]       = 1'b0;
            ev_prev[ch]   = 1'b0;
        end
        for (int m = 0; m < 3; m++) begin
            free_e[m] = 0;
            q_m[m]    = 1'b0;
            exp_v[m]  = 6'b0;
        end
    endtask

    task automatic model_step();
        bit ev_now[2];
        bit all_diff;
        bit se, re, ce, de;
        n++;
        hist[0][n % 64] = set_raw;
        hist[1][n % 64] = clr_raw;
        for (int ch = 0; ch < 2; ch++) begin
            ev_now[ch] = 1'b0;
            if (n - DB + 1 > last_flip[ch]) begin
                all_diff = 1'b1;
                for (int k = n - DB + 1; k <= n; k++)
                    if (synced(ch, k) == lvl[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    lvl[ch]       = ~lvl[ch];
                    last_flip[ch] = n;
                    ev_now[ch]    = lvl[ch];
                end
            end
        end
        for (int m = 0; m < 3; m++) begin
            se = 1'b0; re = 1'b0; ce = 1'b0; de = 1'b0;
            if (ev_prev[0] || ev_prev[1]) begin
                if (n >= free_e[m]) begin
                    if (ev_prev[0] && ev_prev[1]) begin
                        ce = 1'b1;
                        if (m == 1) se = 1'b1;
                        if (m == 2) re = 1'b1;
                    end else begin
                        se = ev_prev[0];
                        re = ev_prev[1];
                    end
                    if (se || re) free_e[m] = n + 2 + LOCK;
                end else begin
                    de = 1'b1;
                end
            end
            if (se) q_m[m] = 1'b1;
            else if (re) q_m[m] = 1'b0;
            exp_v[m] = {se, re, q_m[m], (n < free_e[m] - 1), ce, de};
        end
        ev_prev = ev_now;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // ---------------- tests ----------------
    task automatic do_reset(input logic sv, input logic cv);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        set_raw = sv;
        clr_raw = cv;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        int s_first = -1;
        int s_cnt   = 0;
        @(negedge clk);
        reset = 1'b1; set_raw = 1'b1; clr_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== 6'b0) $display("FAIL reset_hold dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), 6'b0);
                else n_pass++;
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_v[m]) $display("FAIL reset_release dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), exp_v[m]);
                else n_pass++;
            end
            if (s_w[1]) begin
                s_cnt++;
                if (s_first < 0) s_first = i;
            end
        end
        n_checks++;
        if (s_first !== 6) $display("FAIL reset_release_latency: got %0d want %0d", s_first, 6);
        else n_pass++;
        n_checks++;
        if (s_cnt !== 1) $display("FAIL reset_release_pulses: got %0d want %0d", s_cnt, 1);
        else n_pass++;
    endtask

    task automatic test_single_set();
        int busy_cnt = 0;
        int r_cnt    = 0;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_v[m]) $display("FAIL single_set dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), exp_v[m]);
                else n_pass++;
            end
            if (busy_w[0]) busy_cnt++;
            if (r_w[0]) r_cnt++;
            if (i == 6) begin
                n_checks++;
                if ({s_w[0], q_w[0]} !== 2'b11) $display("FAIL single_set_edge6: got s,q=%b want %b", {s_w[0], q_w[0]}, 2'b11);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_cnt !== 1 + LOCK) $display("FAIL single_set_busy: got %0d want %0d", busy_cnt, 1 + LOCK);
        else n_pass++;
        n_checks++;
        if ({r_cnt, q_w[0]} !== {32'd0, 1'b1}) $display("FAIL single_set_end: got r_cnt=%0d q=%b want 0/1", r_cnt, q_w[0]);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int s_cnt = 0;
        int d_cnt = 0;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_v[m]) $display("FAIL glitch dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), exp_v[m]);
                else n_pass++;
            end
            if (s_w[0]) s_cnt++;
            if (drop_w[0]) d_cnt++;
            if (i == 1) set_raw = 1'b0;
        end
        n_checks++;
        if ({s_cnt, d_cnt, q_w[0]} !== {32'd0, 32'd0, 1'b0}) $display("FAIL glitch_summary: got s=%0d drop=%0d q=%b want 0/0/0", s_cnt, d_cnt, q_w[0]);
        else n_pass++;
    endtask

    task automatic test_conflict();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_v[m]) $display("FAIL conflict dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), exp_v[m]);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if ({s_w[0], r_w[0], conf_w[0]} !== 3'b001) $display("FAIL conflict_drop_mode: got s,r,conflict=%b want %b", {s_w[0], r_w[0], conf_w[0]}, 3'b001);
                else n_pass++;
                n_checks++;
                if ({s_w[2], r_w[2], q_w[2], conf_w[2]} !== 4'b0101) $display("FAIL conflict_clr_wins: got s,r,q,conflict=%b want %b", {s_w[2], r_w[2], q_w[2], conf_w[2]}, 4'b0101);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lockout_drop();
        int r_early = 0;
        int r_late  = 0;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_v[m]) $display("FAIL lockout dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), exp_v[m]);
                else n_pass++;
            end
            if (r_w[0] && i < 20) r_early++;
            if (r_w[0] && i >= 20) r_late++;
            if (i == 8) begin
                n_checks++;
                if (drop_w[0] !== 1'b1) $display("FAIL lockout_drop: got %b want %b", drop_w[0], 1'b1);
                else n_pass++;
            end
            if (i == 1)  clr_raw = 1'b1;
            if (i == 12) clr_raw = 1'b0;
            if (i == 22) clr_raw = 1'b1;
        end
        n_checks++;
        if ({r_early, r_late, q_w[0]} !== {32'd0, 32'd1, 1'b0}) $display("FAIL lockout_retry: got early=%0d late=%0d q=%b want 0/1/0", r_early, r_late, q_w[0]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b0);
        repeat (7) @(negedge clk);
        n_checks++;
        if (s_w[0] !== 1'b1) $display("FAIL async_reset_pre: got s=%b want %b", s_w[0], 1'b1);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (dut_vec(m) !== 6'b0) $display("FAIL async_reset dut%0d: got %b want %b", m, dut_vec(m), 6'b0);
            else n_pass++;
        end
        @(negedge clk);
        set_raw = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_random();
        int hs = 1;
        int hc = 1;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_v[m]) $display("FAIL random dut%0d cyc %0d: got %b want %b", m, i, dut_vec(m), exp_v[m]);
                else n_pass++;
                n_checks++;
                if ((s_w[m] & r_w[m]) !== 1'b0) $display("FAIL random_exclusive dut%0d cyc %0d: got s&r=%b want 0", m, i, s_w[m] & r_w[m]);
                else n_pass++;
            end
            hs--;
            hc--;
            if (hs == 0) begin set_raw = ~set_raw; hs = $urandom_range(1, 12); end
            if (hc == 0) begin clr_raw = ~clr_raw; hc = $urandom_range(1, 12); end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_glitch();
        test_conflict();
        test_lockout_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
- Upstream front end for the SR flip-flop stage.
- Takes two raw, asynchronous request lines (set button, clear button) and synchronizes and debounces each one.
- Converts rising edges into single-cycle s/r command pulses, and guarantees s and r are never high together.
- Enforces a lockout gap between commands and keeps a mirror of the expected flip-flop state for checking.

Parameters:
DB_CYCLES, 4, consecutive stable samples before a debounced level changes (1..255)
LOCK_CYCLES, 3, idle cycles enforced after each issued pulse (0..255)
CONFLICT_MODE, 0, simultaneous set+clear events: 0 = drop both, 1 = set wins, 2 = clear wins

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
set_raw  input  1  raw set request, asynchronous to clk
clr_raw  input  1  raw clear request, asynchronous to clk
s  output  1  registered one-cycle set command to the SR flip-flop
r  output  1  registered one-cycle reset command to the SR flip-flop
q_model  output  1  expected flip-flop state after issued commands
busy  output  1  high when the FSM is not in IDLE
conflict  output  1  one-cycle flag: simultaneous events were resolved or dropped
drop  output  1  one-cycle flag: an event arrived while busy and was discarded

Behaviour:
- Reset (async, active-high):
  - All registers clear immediately, without waiting for clk.
  - s=0, r=0, q_model=0, busy=0, conflict=0, drop=0; FSM goes to IDLE.
  - Sync flops, debounced levels and counters are all 0.
- Per input channel:
  - 2-flop synchronizer, then debouncer.
  - The debounce counter is 8 bits. It increments on each cycle where the synced value differs from the debounced level, and clears on any equal cycle.
  - The debounced level takes the synced value at the edge that takes the DB_CYCLES-th consecutive differing sample.
  - A debounced 0->1 transition raises that channel's event for exactly one cycle. 1->0 transitions produce no event.
- Latency: edge 0 is the first edge that samples raw high. The debounced level rises at edge DB_CYCLES+1, and s/r are high during the cycle after edge DB_CYCLES+2 (edge 6 for the default DB_CYCLES=4).
- FSM state IDLE:
  - Set event only -> s=1 next edge, go to PULSE.
  - Clear event only -> r=1 next edge, go to PULSE.
  - Both events, CONFLICT_MODE=0 -> no pulse, conflict=1 for one cycle, stay IDLE.
  - Both events, CONFLICT_MODE=1 -> s pulse plus conflict=1.
  - Both events, CONFLICT_MODE=2 -> r pulse plus conflict=1.
- FSM state PULSE:
  - Lasts exactly one cycle; s/r deassert at the following edge.
  - Go to LOCKOUT if LOCK_CYCLES>0, else to IDLE.
- FSM state LOCKOUT:
  - Stays for LOCK_CYCLES cycles (8-bit counter), then goes to IDLE.
- Events in PULSE or LOCKOUT are discarded, with drop=1 for one cycle. They are never queued.
- q_model is set to 1 at the edge that asserts s and cleared to 0 at the edge that asserts r. Otherwise it holds.
- Invariant: s & r never equal 1.
- A raw input held high through reset release is treated as a new 0->1 transition and produces an event once debounce completes.
- Raw glitches shorter than DB_CYCLES synced cycles produce no event and leave the counter cleared.

Decomposition:
- Shared include file sr_defines.vh holds:
  - FSM state encodings IDLE=2'd0, PULSE=2'd1, LOCKOUT=2'd2.
  - CONFLICT_MODE constants DROP=0, SET_WINS=1, CLR_WINS=2.
- One natural sub-module, sr_sync_debounce, contains the synchronizer, debounce counter and rising-edge event. It is instantiated twice, once for set_raw and once for clr_raw; the top level holds the FSM, lockout counter and q_model.

Test Plan:
1. reset=1 with set_raw=clr_raw=1 -> s=r=q_model=busy=0 throughout. Release reset -> s pulse after edge 6; raws stay high, no further pulses.
2. set_raw rises before edge 0, held high -> s=1 for one cycle after edge 6, q_model=1 from edge 6, busy high 4 cycles (PULSE + 3 LOCKOUT), r stays 0.
3. set_raw high for 3 cycles, then low -> no s pulse, q_model unchanged, drop=0.
4. Both raws rise at the same edge, CONFLICT_MODE=0 -> no pulse, conflict=1 one cycle at edge 6. Rerun with CONFLICT_MODE=2 -> r pulse only, conflict=1, q_model=0.
5. After a set pulse, clr_raw rises so its event lands inside LOCKOUT -> drop=1, no r. Toggle clr_raw low/high after lockout -> r pulse, q_model=0.
6. Assert reset asynchronously mid-cycle while s=1 -> s falls before the next clk edge, FSM IDLE, q_model=0, busy=0.
